// File: rtl/bids_nx_controller.sv
// bids_nx_controller: N-bidder auction controller.
// A host issues opcodes (C_op/C_data/C_idx, qualified by C_start) to load
// balances, set the mask, round timer and per-bid charge, lock/unlock the
// block, and open/close rounds. During a round the bidders submit bids. The
// block charges every accepted bid, tracks the leader, deducts the winning
// amount at round end and pulses win/roundOver.
// Ports:
//   clk, reset_n             clock, synchronous active-low reset
//   C_op/C_data/C_idx        host opcode, operand, LoadBal bidder select
//   C_start                  opcode valid strobe
//   bidAmt/bid/retract       per-bidder bid amount, bid and retract requests
//   ack/err                  per-bidder acknowledge pulse and 2-bit code
//   balance                  per-bidder balances, flattened
//   win/roundOver            winner pulse, round end pulse
//   ready/ctl_err            control ops accepted, control error pulse
//   maxBid                   current or final leading bid
//
// state       | meaning
// ST_LOCKED   | control ops blocked until Unlock with the matching key
// ST_UNLOCKED | configuration and round start accepted
// ST_ROUND    | bidding open, timer counting down
module bids_nx_controller #(
  parameter int N_BIDDERS = 3,
  parameter int BID_W = 16,
  parameter int BAL_W = 32,
  parameter int TIMER_W = 16,
  parameter logic [TIMER_W-1:0] DEF_TIMER = 16'hFFFF,
  parameter int IDX_W = (N_BIDDERS > 1) ? $clog2(N_BIDDERS) : 1
) (
  input  logic                         clk,
  input  logic                         reset_n,
  input  logic [3:0]                   C_op,
  input  logic [31:0]                  C_data,
  input  logic [IDX_W-1:0]             C_idx,
  input  logic                         C_start,
  input  logic [BID_W*N_BIDDERS-1:0]   bidAmt,
  input  logic [N_BIDDERS-1:0]         bid,
  input  logic [N_BIDDERS-1:0]         retract,
  output logic [N_BIDDERS-1:0]         ack,
  output logic [2*N_BIDDERS-1:0]       err,
  output logic [BAL_W*N_BIDDERS-1:0]   balance,
  output logic [N_BIDDERS-1:0]         win,
  output logic                         ready,
  output logic [2:0]                   ctl_err,
  output logic                         roundOver,
  output logic [BID_W-1:0]             maxBid
);

  localparam logic [3:0] OP_NOP = 4'd0, OP_UNLOCK = 4'd1, OP_LOCK = 4'd2,
                         OP_LOADBAL = 4'd3, OP_SETMASK = 4'd4, OP_SETTIMER = 4'd5,
                         OP_CHARGE = 4'd6, OP_ACTIVE = 4'd7, OP_CLOSE = 4'd8;
  localparam logic [IDX_W:0] N_LIM = (IDX_W+1)'(N_BIDDERS);

  typedef enum logic [1:0] {ST_LOCKED, ST_UNLOCKED, ST_ROUND} state_t;

  state_t                state, nx_state;
  logic [31:0]           key, nx_key;
  logic [N_BIDDERS-1:0]  mask, nx_mask;
  logic [TIMER_W-1:0]    timer_load, nx_timer_load, timer, nx_timer;
  logic [BID_W-1:0]      charge, nx_charge, nx_max_bid;
  logic [BAL_W-1:0]      bal [N_BIDDERS];
  logic [BAL_W-1:0]      nx_bal [N_BIDDERS];
  logic                  leader_vld, nx_leader_vld;
  logic [IDX_W-1:0]      leader, nx_leader;
  logic [N_BIDDERS-1:0]  nx_ack, nx_win, acc;
  logic [2*N_BIDDERS-1:0] nx_err;
  logic [2:0]            nx_ctl_err;
  logic                  nx_round_over, round_end, found;
  logic [BID_W-1:0]      amt, best_amt;
  logic [IDX_W-1:0]      best_idx;
  logic [BAL_W:0]        need;

  always_ff @(posedge clk) begin
    if (!reset_n) begin
      state      <= ST_UNLOCKED;
      key        <= '0;
      mask       <= '1;
      timer_load <= DEF_TIMER;
      timer      <= DEF_TIMER;
      charge     <= BID_W'(1);
      for (int i = 0; i < N_BIDDERS; i++) bal[i] <= '0;
      leader_vld <= 1'b0;
      leader     <= '0;
      maxBid     <= '0;
      ack        <= '0;
      err        <= '0;
      win        <= '0;
      ctl_err    <= '0;
      roundOver  <= 1'b0;
      ready      <= 1'b1;
    end else begin
      state      <= nx_state;
      key        <= nx_key;
      mask       <= nx_mask;
      timer_load <= nx_timer_load;
      timer      <= nx_timer;
      charge     <= nx_charge;
      for (int i = 0; i < N_BIDDERS; i++) bal[i] <= nx_bal[i];
      leader_vld <= nx_leader_vld;
      leader     <= nx_leader;
      maxBid     <= nx_max_bid;
      ack        <= nx_ack;
      err        <= nx_err;
      win        <= nx_win;
      ctl_err    <= nx_ctl_err;
      roundOver  <= nx_round_over;
      ready      <= (nx_state != ST_ROUND);
    end
  end

  always_comb begin
    for (int i = 0; i < N_BIDDERS; i++) balance[i*BAL_W +: BAL_W] = bal[i];
  end

  always_comb begin
    nx_state      = state;
    nx_key        = key;
    nx_mask       = mask;
    nx_timer_load = timer_load;
    nx_timer      = timer;
    nx_charge     = charge;
    nx_bal        = bal;
    nx_leader_vld = leader_vld;
    nx_leader     = leader;
    nx_max_bid    = maxBid;
    nx_ack        = '0;
    nx_err        = '0;
    nx_win        = '0;
    nx_ctl_err    = '0;
    nx_round_over = 1'b0;
    round_end     = 1'b0;
    acc           = '0;
    found         = 1'b0;
    amt           = '0;
    best_amt      = '0;
    best_idx      = '0;
    need          = '0;

    if (C_start) begin
      if (C_op > OP_CLOSE) begin
        nx_ctl_err = 3'b100;
      end else begin
        case (state)
          ST_UNLOCKED: begin
            case (C_op)
              OP_LOADBAL: begin
                if ({1'b0, C_idx} < N_LIM) begin
                  for (int i = 0; i < N_BIDDERS; i++)
                    if (C_idx == IDX_W'(i)) nx_bal[i] = C_data[BAL_W-1:0];
                end else begin
                  nx_ctl_err = 3'b011;
                end
              end
              OP_SETMASK:  nx_mask = C_data[N_BIDDERS-1:0];
              OP_SETTIMER: nx_timer_load = (C_data[TIMER_W-1:0] == '0) ? DEF_TIMER
                                                                      : C_data[TIMER_W-1:0];
              OP_CHARGE:   nx_charge = C_data[BID_W-1:0];
              OP_LOCK: begin
                nx_key   = C_data;
                nx_state = ST_LOCKED;
              end
              OP_ACTIVE: begin
                nx_state      = ST_ROUND;
                nx_timer      = timer_load;
                nx_max_bid    = '0;
                nx_leader_vld = 1'b0;
              end
              OP_UNLOCK, OP_CLOSE: nx_ctl_err = 3'b001;
              default: ;
            endcase
          end
          ST_LOCKED: begin
            if (C_op == OP_UNLOCK) begin
              if (C_data == key) nx_state = ST_UNLOCKED;
              else nx_ctl_err = 3'b010;
            end else if (C_op != OP_NOP) begin
              nx_ctl_err = 3'b001;
            end
          end
          default: begin
            if (C_op == OP_CLOSE) round_end = 1'b1;
            else if (C_op != OP_NOP) nx_ctl_err = 3'b001;
          end
        endcase
      end
    end

    // Down-counter: the edge that takes it from 1 to 0 is the round end.
    if (state == ST_ROUND) begin
      nx_timer = timer - TIMER_W'(1);
      if (timer <= TIMER_W'(1)) round_end = 1'b1;
    end

    // Bids compare against the registered maxBid; a leader retract clears
    // the lead before same-cycle accepted bids re-establish one.
    for (int i = 0; i < N_BIDDERS; i++) begin
      amt  = bidAmt[i*BID_W +: BID_W];
      need = (BAL_W+1)'(amt) + (BAL_W+1)'(charge);
      if (bid[i]) begin
        nx_ack[i] = 1'b1;
        if (state != ST_ROUND || !mask[i])   nx_err[2*i +: 2] = 2'b01;
        else if (amt <= maxBid)              nx_err[2*i +: 2] = 2'b11;
        else if ({1'b0, bal[i]} < need)      nx_err[2*i +: 2] = 2'b10;
        else begin
          acc[i]    = 1'b1;
          nx_bal[i] = bal[i] - BAL_W'(charge);
        end
      end else if (retract[i]) begin
        nx_ack[i] = 1'b1;
        if (state == ST_ROUND && leader_vld && leader == IDX_W'(i)) begin
          nx_max_bid    = '0;
          nx_leader_vld = 1'b0;
        end else begin
          nx_err[2*i +: 2] = 2'b01;
        end
      end
    end

    // Strict compare keeps the lowest index on ties.
    for (int i = 0; i < N_BIDDERS; i++) begin
      if (acc[i] && (!found || bidAmt[i*BID_W +: BID_W] > best_amt)) begin
        found    = 1'b1;
        best_amt = bidAmt[i*BID_W +: BID_W];
        best_idx = IDX_W'(i);
      end
    end
    if (found) begin
      nx_max_bid    = best_amt;
      nx_leader     = best_idx;
      nx_leader_vld = 1'b1;
    end

    if (round_end) begin
      nx_state      = ST_UNLOCKED;
      nx_round_over = 1'b1;
      if (nx_leader_vld) begin
        for (int i = 0; i < N_BIDDERS; i++) begin
          if (nx_leader == IDX_W'(i)) begin
            nx_bal[i] = nx_bal[i] - BAL_W'(nx_max_bid);
            nx_win[i] = 1'b1;
          end
        end
      end
      nx_leader_vld = 1'b0;
    end
  end

endmodule
